// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. It runs one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle and presents a sign-corrected registered result.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, stall_s;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, res_neg_s;
    logic              div_zero_s, ovf_s, special_s, accept_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, special_val_s;
    logic [XLEN:0]     sum_s, rem_sh_s, diff_s;
    logic [2*XLEN-1:0] acc_next_s, prod_s;
    logic [XLEN-1:0]   fin_val_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (ZERO - v) : v;
    endfunction

    // Operand decode at the issue boundary: signedness, magnitudes, special cases
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        if (funct3[2]) begin
            a_signed_s = ~funct3[0];
            b_signed_s = ~funct3[0];
        end else begin
            a_signed_s = (funct3[1:0] != 2'b11);
            b_signed_s = ~funct3[1];
        end
        a_neg_s    = a_signed_s & rs1_data[XLEN-1];
        b_neg_s    = b_signed_s & rs2_data[XLEN-1];
        a_mag_s    = cond_neg(a_neg_s, rs1_data);
        b_mag_s    = cond_neg(b_neg_s, rs2_data);
        div_zero_s = funct3[2] & (rs2_data == ZERO);
        ovf_s      = funct3[2] & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);
        special_s  = div_zero_s | ovf_s;
        // Remainder takes the dividend's sign; product and quotient the XOR
        if (funct3[2] && funct3[1]) begin
            res_neg_s = a_neg_s;
        end else begin
            res_neg_s = a_neg_s ^ b_neg_s;
        end
        if (div_zero_s) begin
            special_val_s = funct3[1] ? rs1_data : ALL_ONES;
        end else if (funct3[1]) begin
            special_val_s = ZERO;
        end else begin
            special_val_s = MIN_NEG;
        end
    end

    // One iteration of the shared accumulator plus final sign correction
    always_comb begin
        sum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO});
        rem_sh_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_s   = rem_sh_s - {1'b0, opnd_q};
        if (op_q[2]) begin
            acc_next_s = {(diff_s[XLEN] ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0]),
                          acc_q[XLEN-2:0], ~diff_s[XLEN]};
        end else begin
            acc_next_s = {sum_s, acc_q[XLEN-1:1]};
        end
        prod_s = neg_q ? ({(2*XLEN){1'b0}} - acc_next_s) : acc_next_s;
        case (op_q)
            3'b000:                 fin_val_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_val_s = cond_neg(neg_q, acc_next_s[XLEN-1:0]);
            3'b110, 3'b111:         fin_val_s = cond_neg(neg_q, acc_next_s[2*XLEN-1:XLEN]);
            default:                fin_val_s = ZERO;
        endcase
    end

    assign accept_s = (state_q == S_IDLE) && start && !flush;

    // State register and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; flush wins over everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = special_s ? S_FIN : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; stall covers the issue cycle so decode holds until FIN
    always_comb begin
        busy_d  = (state_d == S_CALC);
        done_d  = (state_d == S_FIN);
        stall_s = ((state_q == S_IDLE) && start) || (state_q == S_CALC);
    end

    // Datapath: latch magnitudes on accept, iterate in CALC, load result entering FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'b000;
            neg_q    <= 1'b0;
            opnd_q   <= ZERO;
            acc_q    <= {(2*XLEN){1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= ZERO;
        end else if (accept_s) begin
            op_q   <= funct3;
            neg_q  <= res_neg_s;
            opnd_q <= funct3[2] ? b_mag_s : a_mag_s;
            acc_q  <= {ZERO, (funct3[2] ? a_mag_s : b_mag_s)};
            cnt_q  <= {CW{1'b0}};
            if (special_s) begin
                result_q <= special_val_s;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            acc_q <= acc_next_s;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
                result_q <= fin_val_s;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign stall  = stall_s;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, busy, stall, done;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, result;
    int          checks = 0;
    int          errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'h0) ? ONES : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == MIN && b == ONES) return 32'h0;
                return 32'(ia % ib);
            end
            3'd7: return (b == 32'h0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return MIN;
            2: return ONES;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        logic spec;
        logic exp_busy;
        int   lat;
        int   exp_lat;
        spec     = f[2] && (b == 32'h0 || (!f[0] && a == MIN && b == ONES));
        exp_busy = !spec;
        exp_lat  = spec ? 1 : 33;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL %s issue_stall: got %b expected 1", nm, stall); end
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
            #1;
            if (done === 1'b1) begin
                lat = c;
            end else begin
                checks++;
                if (busy !== exp_busy || stall !== exp_busy) begin
                    errors++;
                    $display("FAIL %s busy_stall cycle %0d: got %b/%b expected %b", nm, c, busy, stall, exp_busy);
                end
            end
        end
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat); end
        checks++;
        if (result !== exp) begin errors++; $display("FAIL %s result: got %h expected %h", nm, result, exp); end
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s fin_stall_busy: got %b/%b expected 0/0", nm, stall, busy); end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL %s hold: got done=%b result=%h expected done=0 result=%h", nm, done, result, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1_data = 32'h0; rs2_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, stall} !== 3'b000 || result !== 32'h0) begin
            errors++; $display("FAIL reset: got busy/done/stall=%b result=%h expected 000 0", {busy, done, stall}, result);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
            #1;
            checks++;
            if ({busy, done, stall} !== 3'b000 || result !== 32'h0) begin
                errors++; $display("FAIL idle_hold: got busy/done/stall=%b result=%h expected 000 0", {busy, done, stall}, result);
            end
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f[10]   = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] a[10]   = '{32'd7, MIN, ONES, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'h1234, 32'h1234, MIN, MIN};
        logic [31:0] b[10]   = '{32'hFFFF_FFFD, MIN, ONES, 32'd2, 32'd2, 32'd2, 32'h0, 32'h0, ONES, ONES};
        logic [31:0] exp[10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, ONES,
                                 32'h7FFF_FFFC, ONES, 32'h1234, MIN, 32'h0};
        for (int i = 0; i < 10; i++) begin
            run_op(f[i], a[i], b[i], exp[i], $sformatf("directed%0d", i));
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(f, a, b, ref_model(f, a, b), $sformatf("random%0d_op%0d", i, f));
        end
    endtask

    task automatic test_flush();
        run_op(3'd0, 32'd6, 32'd7, 32'd42, "pre_flush");
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (c == 10);
            #1;
            checks++;
            if (c <= 10 && (busy !== 1'b1 || done !== 1'b0)) begin
                errors++; $display("FAIL flush_pre cycle %0d: got busy=%b done=%b expected 1 0", c, busy, done);
            end else if (c == 11 && (busy !== 1'b0 || done !== 1'b0 || result !== 32'd42)) begin
                errors++; $display("FAIL flush_abort: got busy=%b done=%b result=%h expected 0 0 0000002a", busy, done, result);
            end
        end
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "post_flush_mul");
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd4; rs1_data = 32'd9; rs2_data = 32'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_priority: got busy=%b done=%b expected 0 0", busy, done); end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd15) begin errors++; $display("FAIL flush_priority_hold: got done=%b result=%h expected 0 0000000f", done, result); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  fq[102];
        logic [31:0] aq[102];
        logic [31:0] bq[102];
        int ndone = 0;
        for (int c = 0; c <= 101; c++) begin
            @(negedge clk);
            fq[c] = 3'($urandom); aq[c] = $urandom; bq[c] = $urandom | 32'h1;
            if (bq[c] == ONES) bq[c] = 32'd3;
            start = 1'b1; funct3 = fq[c]; rs1_data = aq[c]; rs2_data = bq[c];
            #1;
            checks++;
            if (stall !== ((c % 34) != 33)) begin errors++; $display("FAIL b2b_stall cycle %0d: got %b expected %b", c, stall, (c % 34) != 33); end
            if (done === 1'b1) begin
                checks++;
                if (c != 33 + 34 * ndone) begin
                    errors++; $display("FAIL b2b_done_cycle: got %0d expected %0d", c, 33 + 34 * ndone);
                end else begin
                    checks++;
                    if (result !== ref_model(fq[c-33], aq[c-33], bq[c-33])) begin
                        errors++; $display("FAIL b2b_result cycle %0d: got %h expected %h", c, result, ref_model(fq[c-33], aq[c-33], bq[c-33]));
                    end
                end
                ndone++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ndone != 3 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got dones=%0d busy=%b done=%b expected 3 0 0", ndone, busy, done);
        end
    endtask

    task automatic test_reset_midcalc();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_midcalc: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, stall} !== 3'b000 || result !== 32'h0) begin
            errors++; $display("FAIL reset_release: got busy/done/stall=%b result=%h expected 000 0", {busy, done, stall}, result);
        end
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "after_reset_divu");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_midcalc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
